// File: rtl/d_cache_write_port_if.sv
// Shared types and the store-queue -> d-cache write request interface.
// The requester drives the "out" side; the cache responds on the "in" side.
package d_cache_pkg;
   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } mem_action_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } cache_output_t;
endpackage

interface d_cache_input_ifc;
   import d_cache_pkg::*;

   logic        valid;
   mem_action_t mem_action;
   logic [31:0] addr;
   logic [31:0] addr_next;
   logic [31:0] data;

   modport in  (input  valid, mem_action, addr, addr_next, data);
   modport out (output valid, mem_action, addr, addr_next, data);
endinterface

// File: rtl/d_cache_write_port.sv
// Write-through, no-allocate store port over a direct-mapped one-word-line array.
// Response 3 cycles after acceptance plus memory ack wait; requests are ignored while busy.
module d_cache_write_port
   import d_cache_pkg::*;
#(
   parameter int LINES = 16,
   parameter int IDX_W = $clog2(LINES)
) (
   input  logic                clk,
   input  logic                rst_n,
   d_cache_input_ifc.in        i_req,
   output cache_output_t       o_response,
   output logic                o_mem_valid,
   output logic [31:0]         o_mem_addr,
   output logic [31:0]         o_mem_data,
   input  logic                i_mem_ack,
   input  logic                i_fill_valid,
   input  logic [31:0]         i_fill_addr,
   input  logic [31:0]         i_fill_data,
   input  logic [31:0]         i_rd_addr,
   output logic                o_rd_hit,
   output logic [31:0]         o_rd_data,
   output logic                o_busy,
   output logic                o_protocol_error
);
   localparam int TAG_W = 32 - IDX_W - 2;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      MEM_WRITE,
      RESPOND
   } state_t;

   state_t             state, state_nxt;
   logic               accept, read_err, lookup_hit;
   logic [31:0]        st_addr, st_data;
   logic [LINES-1:0]   line_vld;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [31:0]        data_q [LINES];
   logic [IDX_W-1:0]   st_idx, fill_idx, rd_idx;
   logic [TAG_W-1:0]   st_tag, fill_tag, rd_tag;
   logic               unused_bits;

   assign st_idx   = st_addr[IDX_W+1:2];
   assign st_tag   = st_addr[31:IDX_W+2];
   assign fill_idx = i_fill_addr[IDX_W+1:2];
   assign fill_tag = i_fill_addr[31:IDX_W+2];
   assign rd_idx   = i_rd_addr[IDX_W+1:2];
   assign rd_tag   = i_rd_addr[31:IDX_W+2];

   assign unused_bits = ^{i_req.addr_next, i_req.addr[1:0], i_fill_addr[1:0], i_rd_addr[1:0]};

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      read_err  = 1'b0;
      case (state)
         IDLE: begin
            if (i_req.valid) begin
               if (i_req.mem_action == WRITE) begin
                  accept    = 1'b1;
                  state_nxt = LOOKUP;
               end else begin
                  read_err  = 1'b1;
               end
            end
         end
         LOOKUP:    state_nxt = MEM_WRITE;
         MEM_WRITE: if (i_mem_ack) state_nxt = RESPOND;
         RESPOND:   state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= IDLE;
         st_addr          <= '0;
         st_data          <= '0;
         o_protocol_error <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            st_addr <= {i_req.addr[31:2], 2'b00};
            st_data <= i_req.data;
         end
         if (read_err) o_protocol_error <= 1'b1;
      end
   end

   assign lookup_hit = (state == LOOKUP) && line_vld[st_idx] && (tag_q[st_idx] == st_tag);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         line_vld <= '0;
      end else if (i_fill_valid) begin
         line_vld[fill_idx] <= 1'b1;
      end
   end

   // The committed store is younger than a same-cycle fill, so its data write comes last.
   always_ff @(posedge clk) begin
      if (i_fill_valid) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= i_fill_data;
      end
      if (lookup_hit) begin
         data_q[st_idx] <= st_data;
      end
   end

   assign o_rd_hit  = line_vld[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign o_rd_data = o_rd_hit ? data_q[rd_idx] : '0;

   assign o_mem_valid       = (state == MEM_WRITE);
   assign o_mem_addr        = st_addr;
   assign o_mem_data        = st_data;
   assign o_response.valid  = (state == RESPOND);
   assign o_response.data   = (state == RESPOND) ? st_data : '0;
   assign o_busy            = (state != IDLE);
endmodule

// File: tb/tb_d_cache_write_port.sv
// Randomised scoreboard bench for d_cache_write_port with a line-level reference model.
module tb_d_cache_write_port;
   import d_cache_pkg::*;

   localparam int LINES = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   cache_output_t resp;
   logic          mem_valid, mem_ack, fill_valid, rd_hit, busy, perr;
   logic [31:0]   mem_addr, mem_data, fill_addr, fill_data, rd_addr, rd_data;

   d_cache_input_ifc req_if ();

   d_cache_write_port #(.LINES(LINES)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_req            (req_if),
      .o_response       (resp),
      .o_mem_valid      (mem_valid),
      .o_mem_addr       (mem_addr),
      .o_mem_data       (mem_data),
      .i_mem_ack        (mem_ack),
      .i_fill_valid     (fill_valid),
      .i_fill_addr      (fill_addr),
      .i_fill_data      (fill_data),
      .i_rd_addr        (rd_addr),
      .o_rd_hit         (rd_hit),
      .o_rd_data        (rd_data),
      .o_busy           (busy),
      .o_protocol_error (perr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          len;
   } mem_exp_t;

   int          checks = 0, failures = 0;
   int          cyc = 0, resp_cnt = 0, mem_cnt = 0, ack_delay = 0;
   logic [31:0] exp_resp [$];
   mem_exp_t    exp_mem  [$];

   // Reference model: each line remembers which word address it holds.
   bit          m_vld  [LINES];
   logic [31:0] m_addr [LINES];
   logic [31:0] m_data [LINES];

   always @(posedge clk) cyc++;

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 2) % LINES);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Memory responder: acks after ack_delay wait cycles.
   initial begin
      int wcnt;
      wcnt    = 0;
      mem_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (mem_valid) begin
            if (wcnt >= ack_delay) begin
               mem_ack = 1'b1;
               wcnt    = 0;
            end else begin
               mem_ack = 1'b0;
               wcnt++;
            end
         end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a response or memory write.
   mem_exp_t cur;
   int       mem_len = 0;
   bit       mem_prev = 1'b0;
   always @(negedge clk) begin
      if (resp.valid) begin
         resp_cnt++;
         if (exp_resp.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_response actual=%h expected=none", resp.data);
         end else begin
            chk("resp_data", resp.data, exp_resp.pop_front());
         end
      end
      if (mem_valid) begin
         if (!mem_prev) begin
            mem_cnt++;
            mem_len = 1;
            if (exp_mem.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_mem_write actual=%h expected=none", mem_addr);
               cur = '{addr: mem_addr, data: mem_data, len: 0};
            end else begin
               cur = exp_mem.pop_front();
               chk("mem_addr", mem_addr, cur.addr);
               chk("mem_data", mem_data, cur.data);
            end
         end else begin
            mem_len++;
            chk("mem_addr_stable", mem_addr, cur.addr);
            chk("mem_data_stable", mem_data, cur.data);
         end
      end else if (mem_prev) begin
         chk("mem_valid_len", mem_len, cur.len);
      end
      mem_prev = mem_valid;
   end

   task automatic chk_rd(input logic [31:0] a);
      int i;
      bit h;
      rd_addr = a;
      #1;
      i = idx_of(a);
      h = m_vld[i] && (m_addr[i] == {a[31:2], 2'b00});
      chk("rd_hit", rd_hit, h);
      chk("rd_data", rd_data, h ? m_data[i] : 32'h0);
   endtask

   task automatic fill(input logic [31:0] a, input logic [31:0] d);
      int i;
      fill_valid = 1'b1; fill_addr = a; fill_data = d;
      @(posedge clk); #1;
      fill_valid = 1'b0;
      i = idx_of(a);
      m_vld[i] = 1'b1; m_addr[i] = {a[31:2], 2'b00}; m_data[i] = d;
   endtask

   task automatic end_req();
      req_if.valid = 1'b0;
      @(posedge clk); #1;
   endtask

   // Issue one store at posedge+1; off=1 when the DUT is still in RESPOND of the previous store.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int delay,
                           input int off, input bit fill_hit, input logic [31:0] fd);
      int          c0, i;
      bit          got, old_h, new_h;
      logic [31:0] wa, old_d, new_d;
      wa    = {a[31:2], 2'b00};
      i     = idx_of(a);
      old_h = m_vld[i] && (m_addr[i] == wa);
      old_d = old_h ? m_data[i] : 32'h0;
      if (fill_hit) begin
         m_vld[i] = 1'b1; m_addr[i] = wa; m_data[i] = fd;
      end
      if (m_vld[i] && (m_addr[i] == wa)) m_data[i] = d;
      new_h = m_vld[i] && (m_addr[i] == wa);
      new_d = new_h ? m_data[i] : 32'h0;
      ack_delay = delay;
      exp_mem.push_back('{addr: wa, data: d, len: delay + 1});
      exp_resp.push_back(d);
      req_if.valid      = 1'b1;
      req_if.mem_action = WRITE;
      req_if.addr       = a;
      req_if.addr_next  = $urandom;
      req_if.data       = d;
      c0  = cyc;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(posedge clk); #1;
         if (cyc == c0 + 1 + off) begin
            if (fill_hit) begin
               fill_valid = 1'b1; fill_addr = a; fill_data = fd;
            end
            rd_addr = a; #1;
            chk("rd_hit_in_lookup", rd_hit, old_h);
            chk("rd_data_in_lookup", rd_data, old_d);
         end else if (cyc == c0 + 2 + off) begin
            fill_valid = 1'b0;
            rd_addr = a; #1;
            chk("rd_hit_after_lookup", rd_hit, new_h);
            chk("rd_data_after_lookup", rd_data, new_d);
         end
         if (resp.valid) begin
            got = 1'b1;
            chk("resp_latency", cyc - c0, 3 + delay + off);
         end
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL store_timeout actual=no_response expected=response addr=%h", a);
      end
   endtask

   initial begin
      int          r0, m0, c0;
      logic [31:0] a;
      logic [31:0] saved [$];

      rst_n = 1'b0;
      req_if.valid = 1'b0; req_if.mem_action = READ; req_if.addr = '0;
      req_if.addr_next = '0; req_if.data = '0;
      fill_valid = 1'b0; fill_addr = '0; fill_data = '0; rd_addr = '0;
      for (int i = 0; i < LINES; i++) begin
         m_vld[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      chk("reset_busy", busy, 1'b0);
      chk("reset_mem_valid", mem_valid, 1'b0);
      chk("reset_resp_valid", resp.valid, 1'b0);
      chk("reset_resp_data", resp.data, 32'h0);
      chk("reset_perr", perr, 1'b0);
      chk_rd(32'h100);

      // Miss: written through, not allocated.
      do_store(32'h100, 32'hDEADBEEF, 0, 0, 1'b0, 0);
      end_req();
      chk_rd(32'h100);

      // Hit after fill.
      fill(32'h140, 32'h11);
      chk_rd(32'h140);
      do_store(32'h140, 32'h22, 0, 0, 1'b0, 0);
      end_req();
      chk_rd(32'h140);

      // Slow memory, unaligned request address.
      do_store(32'h107, 32'hCAFE0001, 5, 0, 1'b0, 0);
      end_req();

      // Back-to-back with valid held across the response.
      r0 = resp_cnt; m0 = mem_cnt;
      do_store(32'h200, 32'hA5A5_0001, 0, 0, 1'b0, 0);
      do_store(32'h204, 32'hA5A5_0002, 1, 1, 1'b0, 0);
      end_req();
      repeat (4) @(posedge clk);
      #1;
      chk("b2b_responses", resp_cnt - r0, 2);
      chk("b2b_mem_writes", mem_cnt - m0, 2);

      // READ on the write port is refused and flagged.
      r0 = resp_cnt; m0 = mem_cnt;
      req_if.valid = 1'b1; req_if.mem_action = READ; req_if.addr = 32'h300;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("read_busy", busy, 1'b0);
         chk("read_perr", perr, 1'b1);
      end
      end_req();
      repeat (3) @(posedge clk);
      #1;
      chk("read_no_response", resp_cnt - r0, 0);
      chk("read_no_mem_write", mem_cnt - m0, 0);

      // Fill collides with the LOOKUP hit on the same line.
      fill(32'h180, 32'h1);
      do_store(32'h180, 32'h9, 0, 0, 1'b1, 32'h5);
      end_req();
      chk_rd(32'h180);

      // Random fills, stores and lookups over a small colliding address pool.
      for (int n = 0; n < 40; n++) begin
         a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 2) == 0) begin
            fill(a, $urandom);
         end else begin
            do_store(a, $urandom, $urandom_range(0, 3), 0, 1'b0, 0);
            end_req();
         end
         a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2);
         chk_rd(a);
      end
      repeat (5) @(posedge clk);
      #1;
      chk("perr_sticky", perr, 1'b1);
      chk("resp_queue_drained", exp_resp.size(), 0);
      chk("mem_queue_drained", exp_mem.size(), 0);

      // Reset in MEM_WRITE drops the store.
      for (int i = 0; i < LINES; i++) if (m_vld[i]) saved.push_back(m_addr[i]);
      saved.push_back(32'h1C0);
      r0 = resp_cnt;
      ack_delay = 1000;
      exp_mem.push_back('{addr: 32'h1C0, data: 32'h7777, len: 3});
      req_if.valid = 1'b1; req_if.mem_action = WRITE; req_if.addr = 32'h1C0; req_if.data = 32'h7777;
      c0 = cyc;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_test_mem_valid", mem_valid, 1'b1);
      req_if.valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_cycles", cyc - c0, 5);
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_resp_valid", resp.valid, 1'b0);
      chk("rst_perr", perr, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < LINES; i++) m_vld[i] = 1'b0;
      foreach (saved[j]) chk_rd(saved[j]);
      repeat (6) @(posedge clk);
      #1;
      chk("rst_no_response", resp_cnt - r0, 0);
      chk("rst_mem_queue", exp_mem.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/d_cache_write_port.md
Name: d_cache_write_port

Overview:
- Responder end of the data-cache write request interface: the d-cache side that services WRITE requests from the store queue at commit.
- Each accepted store is written through: a small direct-mapped data array is updated on a tag hit (no allocate on miss), and the store is always forwarded to backing memory.
- The requester gets exactly one single-cycle response.valid per completed store.
- Also provides a combinational read-lookup port and a line-fill port for the load path.

Parameters:
LINES, 16, number of direct-mapped one-word lines (power of 2, >=2)
IDX_W, $clog2(LINES), index width; index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2]

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_req  d_cache_input_ifc.in  -  fields valid(1), mem_action(READ/WRITE), addr(32), addr_next(32, ignored), data(32)
o_response  out  cache_output_t  valid(1) pulse per completed store; data(32) = stored data
o_mem_valid  out  1  write request to backing memory
o_mem_addr  out  32  word-aligned store address (addr[1:0] forced 0)
o_mem_data  out  32  store data
i_mem_ack  in  1  memory accepted/completed the write
i_fill_valid  in  1  install line from load path
i_fill_addr  in  32  fill address
i_fill_data  in  32  fill data
i_rd_addr  in  32  lookup address
o_rd_hit  out  1  combinational: line valid and tag match
o_rd_data  out  32  combinational line data ('0 when not hit)
o_busy  out  1  state != IDLE
o_protocol_error  out  1  sticky: READ action seen on i_req.valid

Behaviour:
- State machine: IDLE -> LOOKUP -> MEM_WRITE -> RESPOND -> IDLE.
- IDLE:
  - i_req.valid && mem_action==WRITE: latch addr (aligned down) and data; go to LOOKUP.
  - valid with READ: not accepted, stay in IDLE, set o_protocol_error (sticky until reset).
- LOOKUP (1 cycle): compare latched tag with tag[index].
  - Hit (line valid and tag equal): data[index] <= latched data at the clock edge.
  - Miss: arrays untouched.
  - Always go to MEM_WRITE.
- MEM_WRITE:
  - o_mem_valid=1 with o_mem_addr/o_mem_data stable every cycle until i_mem_ack.
  - i_mem_ack in this state: go to RESPOND. Ack is ignored in every other state.
- RESPOND:
  - o_response.valid=1 and o_response.data=latched data for exactly one cycle, then IDLE.
  - The requester retires its entry on this pulse. The following IDLE cycle samples the next request, so one store is never double-accepted.
- Latency: request seen in cycle 0 with ack in the first MEM_WRITE cycle (cycle 2) gives response in cycle 3. Each extra ack wait cycle adds 1. Max throughput is 1 store per 4 cycles.
- Requests present while not IDLE are ignored. The requester holds the request until response.
- Fill:
  - Any state: i_fill_valid writes tag/data/valid for the fill index.
  - Fill and LOOKUP-hit write on the same index in the same cycle: the store data wins, and the tag/valid from the fill are still written. The fill is older than the committed store.
- Lookup:
  - Pure combinational over registered arrays.
  - A store updated in LOOKUP is visible on o_rd_* the next cycle.
- Reset:
  - All line valid bits 0; state IDLE.
  - o_mem_valid=0, o_response.valid=0, o_response.data=0, o_busy=0, o_protocol_error=0.
  - Reset mid-operation drops the in-flight store with no response. Memory is expected to be reset alongside.
- No flush input: committed stores are architectural and always complete.
- Widths: addresses 32 bit; index/tag slices per parameters; no arithmetic beyond compare.

Test Plan:
- Reset, then WRITE addr=0x100 data=0xDEADBEEF, ack in first MEM_WRITE cycle -> o_mem_valid cycle 2 with addr 0x100; response.valid cycle 3 only, data 0xDEADBEEF; o_rd_hit(0x100)=0 (no allocate).
- Fill 0x140=0x11, then WRITE 0x140=0x22 -> o_rd_data(0x140)=0x22 from cycle after LOOKUP; memory sees 0x140/0x22.
- Ack delayed 5 cycles -> o_mem_valid held 6 cycles, addr/data constant; single response pulse at cycle 8.
- Back-to-back requests (valid held, data changes after response) -> second store accepted in the cycle after RESPOND; exactly two responses, two memory writes, no duplicate.
- READ request on i_req -> no state change, no response, o_protocol_error=1 and stays 1 until rst_n=0.
- Fill 0x180=0x5 in the same cycle as a LOOKUP hit on 0x180 (data 0x9) -> o_rd_data(0x180)=0x9. Separately, assert rst_n=0 during MEM_WRITE -> o_mem_valid=0 the next cycle, no response, all lines miss.
